// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/clear controller: two debounced active-low keys drive a
// three-state FSM whose registered outputs steer a downstream seconds counter.
module stopwatch_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter bit          STOP_AT_END     = 1'b0
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       key_run,
   input  logic       key_clr,
   input  logic       ending,
   output logic       start,
   output logic       pause,
   output logic       cnt_clr,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10
   } state_t;

   localparam logic [19:0] LP_CNT_LAST = 20'(DEBOUNCE_CYCLES - 1);

   // bit 0 = run key, bit 1 = clear key
   logic [1:0]  w_keys;
   logic [1:0]  r_sync1;
   logic [1:0]  r_sync2;
   logic [1:0]  r_deb;
   logic [1:0]  r_deb_d;
   logic [1:0]  r_press;
   logic [19:0] r_cnt [2];

   state_t r_state;
   logic   r_start;
   logic   r_pause;
   logic   r_cnt_clr;

   logic   w_run_press;
   logic   w_clr_press;
   logic   w_end_stop;

   assign w_keys      = {key_clr, key_run};
   assign w_run_press = r_press[0];
   assign w_clr_press = r_press[1];
   assign w_end_stop  = STOP_AT_END && ending;

   // Per-key synchronizer, debounce counter and falling-edge press pulse
   always_ff @(posedge clk) begin
      if (clr) begin
         r_sync1 <= 2'b11;
         r_sync2 <= 2'b11;
         r_deb   <= 2'b11;
         r_deb_d <= 2'b11;
         r_press <= 2'b00;
         for (int k = 0; k < 2; k++) begin
            r_cnt[k] <= 20'd0;
         end
      end else begin
         r_sync1 <= w_keys;
         r_sync2 <= r_sync1;
         r_deb_d <= r_deb;
         r_press <= r_deb_d & ~r_deb;
         for (int k = 0; k < 2; k++) begin
            if (r_sync2[k] == r_deb[k]) begin
               r_cnt[k] <= 20'd0;
            end else if (r_cnt[k] == LP_CNT_LAST) begin
               r_deb[k] <= r_sync2[k];
               r_cnt[k] <= 20'd0;
            end else begin
               r_cnt[k] <= r_cnt[k] + 20'd1;
            end
         end
      end
   end

   // Control FSM; start/pause are decoded from the state being entered so
   // they change on the same edge as the state itself
   always_ff @(posedge clk) begin
      if (clr) begin
         r_state   <= ST_IDLE;
         r_start   <= 1'b0;
         r_pause   <= 1'b0;
         r_cnt_clr <= 1'b0;
      end else begin
         r_cnt_clr <= 1'b0;
         if (w_clr_press) begin
            r_state   <= ST_IDLE;
            r_start   <= 1'b0;
            r_pause   <= 1'b0;
            r_cnt_clr <= 1'b1;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_run_press) begin
                     r_state <= ST_RUN;
                     r_start <= 1'b1;
                     r_pause <= 1'b0;
                  end
               end
               ST_RUN: begin
                  // ending outranks run_press, and both land in PAUSE anyway
                  if (w_end_stop || w_run_press) begin
                     r_state <= ST_PAUSE;
                     r_start <= 1'b1;
                     r_pause <= 1'b1;
                  end
               end
               ST_PAUSE: begin
                  if (w_run_press) begin
                     r_state <= ST_RUN;
                     r_start <= 1'b1;
                     r_pause <= 1'b0;
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_start <= 1'b0;
                  r_pause <= 1'b0;
               end
            endcase
         end
      end
   end

   assign state   = r_state;
   assign start   = r_start;
   assign pause   = r_pause;
   assign cnt_clr = r_cnt_clr;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: two instances (STOP_AT_END 0 and 1)
// share stimulus; every expected output change is queued with its edge number.
module tb_stopwatch_ctrl;

   localparam logic [4:0] V_IDLE  = 5'b00000;
   localparam logic [4:0] V_CLR   = 5'b00001;
   localparam logic [4:0] V_RUN   = 5'b01100;
   localparam logic [4:0] V_PAUSE = 5'b10110;

   typedef struct {
      int         cyc;
      logic [4:0] val;
   } exp_t;

   logic clk = 1'b0;
   logic clr = 1'b1;
   logic key_run = 1'b1;
   logic key_clr = 1'b1;
   logic ending = 1'b0;

   logic       start_a, pause_a, cnt_clr_a;
   logic [1:0] state_a;
   logic       start_b, pause_b, cnt_clr_b;
   logic [1:0] state_b;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;
   exp_t q_a[$];
   exp_t q_b[$];
   logic [4:0] prev_a, prev_b;
   logic [4:0] obs_a, obs_b;

   assign obs_a = {state_a, start_a, pause_a, cnt_clr_a};
   assign obs_b = {state_b, start_b, pause_b, cnt_clr_b};

   stopwatch_ctrl #(.DEBOUNCE_CYCLES(4), .STOP_AT_END(1'b0)) dut_a (
      .clk(clk), .clr(clr), .key_run(key_run), .key_clr(key_clr), .ending(ending),
      .start(start_a), .pause(pause_a), .cnt_clr(cnt_clr_a), .state(state_a)
   );

   stopwatch_ctrl #(.DEBOUNCE_CYCLES(4), .STOP_AT_END(1'b1)) dut_b (
      .clk(clk), .clr(clr), .key_run(key_run), .key_clr(key_clr), .ending(ending),
      .start(start_b), .pause(pause_b), .cnt_clr(cnt_clr_b), .state(state_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor for instance A: every output change must match the queue head
   always @(negedge clk) begin
      exp_t ea;
      if (mon_en && obs_a !== prev_a) begin
         checks++;
         if (q_a.size() == 0) begin
            errors++;
            $display("FAIL dut_a spurious: edge %0d got %b, expected no change", cyc, obs_a);
         end else begin
            ea = q_a.pop_front();
            if (ea.cyc != cyc || ea.val !== obs_a) begin
               errors++;
               $display("FAIL dut_a change: edge %0d got %b, expected edge %0d value %b",
                        cyc, obs_a, ea.cyc, ea.val);
            end
         end
      end
      prev_a = obs_a;
   end

   // Monitor for instance B
   always @(negedge clk) begin
      exp_t eb;
      if (mon_en && obs_b !== prev_b) begin
         checks++;
         if (q_b.size() == 0) begin
            errors++;
            $display("FAIL dut_b spurious: edge %0d got %b, expected no change", cyc, obs_b);
         end else begin
            eb = q_b.pop_front();
            if (eb.cyc != cyc || eb.val !== obs_b) begin
               errors++;
               $display("FAIL dut_b change: edge %0d got %b, expected edge %0d value %b",
                        cyc, obs_b, eb.cyc, eb.val);
            end
         end
      end
      prev_b = obs_b;
   end

   task automatic exp_a(input int c, input logic [4:0] v);
      q_a.push_back(exp_t'{cyc: c, val: v});
   endtask

   task automatic exp_b(input int c, input logic [4:0] v);
      q_b.push_back(exp_t'{cyc: c, val: v});
   endtask

   task automatic exp_both(input int c, input logic [4:0] v);
      exp_a(c, v);
      exp_b(c, v);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drive keys (0 = pressed) for len sampled edges, then release both
   task automatic hold_keys(input logic run_n, input logic clr_n, input int len);
      key_run = run_n;
      key_clr = clr_n;
      repeat (len) @(negedge clk);
      key_run = 1'b1;
      key_clr = 1'b1;
   endtask

   task automatic chk(input string name, input logic [1:0] got, input logic [1:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %b, expected %b", name, got, want);
      end
   endtask

   initial begin
      int e;
      repeat (3) @(posedge clk);
      @(negedge clk);
      clr = 1'b0;
      chk("reset state_a", state_a, 2'b00);
      chk("reset start_a", {1'b0, start_a}, 2'b00);
      chk("reset pause_a", {1'b0, pause_a}, 2'b00);
      chk("reset cnt_clr_a", {1'b0, cnt_clr_a}, 2'b00);
      chk("reset state_b", state_b, 2'b00);
      chk("reset start_b", {1'b0, start_b}, 2'b00);
      chk("reset pause_b", {1'b0, pause_b}, 2'b00);
      chk("reset cnt_clr_b", {1'b0, cnt_clr_b}, 2'b00);
      mon_en = 1'b1;
      idle(2);

      // Held run key: RUN exactly DEBOUNCE_CYCLES+4 edges after first low sample
      @(negedge clk); e = cyc + 1;
      exp_both(e + 7, V_RUN);
      hold_keys(1'b0, 1'b1, 20);
      idle(12);

      // Short glitch ignored, then a clean press pauses
      hold_keys(1'b0, 1'b1, 3);
      idle(12);
      @(negedge clk); e = cyc + 1;
      exp_both(e + 7, V_PAUSE);
      hold_keys(1'b0, 1'b1, 10);
      idle(12);

      // Clear from PAUSE with a single-cycle cnt_clr
      @(negedge clk); e = cyc + 1;
      exp_both(e + 7, V_CLR);
      exp_both(e + 8, V_IDLE);
      hold_keys(1'b1, 1'b0, 10);
      idle(12);

      // Both keys together from RUN: clear wins
      @(negedge clk); e = cyc + 1;
      exp_both(e + 7, V_RUN);
      hold_keys(1'b0, 1'b1, 10);
      idle(12);
      @(negedge clk); e = cyc + 1;
      exp_both(e + 7, V_CLR);
      exp_both(e + 8, V_IDLE);
      hold_keys(1'b0, 1'b0, 10);
      idle(12);

      // ending in RUN pauses only the STOP_AT_END=1 instance
      @(negedge clk); e = cyc + 1;
      exp_both(e + 7, V_RUN);
      hold_keys(1'b0, 1'b1, 10);
      idle(12);
      @(negedge clk); e = cyc + 1;
      exp_b(e, V_PAUSE);
      ending = 1'b1;
      @(negedge clk);
      ending = 1'b0;
      idle(12);

      // Swap: A RUN->PAUSE, B PAUSE->RUN
      @(negedge clk); e = cyc + 1;
      exp_a(e + 7, V_PAUSE);
      exp_b(e + 7, V_RUN);
      hold_keys(1'b0, 1'b1, 10);
      idle(12);

      // ending coincident with run_press: B goes to PAUSE once, A resumes RUN
      @(negedge clk); e = cyc + 1;
      exp_a(e + 7, V_RUN);
      exp_b(e + 7, V_PAUSE);
      key_run = 1'b0;
      repeat (7) @(negedge clk);
      ending = 1'b1;
      @(negedge clk);
      ending = 1'b0;
      repeat (2) @(negedge clk);
      key_run = 1'b1;
      idle(12);

      // Clear from RUN (A) and PAUSE (B)
      @(negedge clk); e = cyc + 1;
      exp_both(e + 7, V_CLR);
      exp_both(e + 8, V_IDLE);
      hold_keys(1'b1, 1'b0, 10);
      idle(12);

      // Long hold: one RUN event; clr mid-hold; still-held key is a fresh press
      @(negedge clk); e = cyc + 1;
      exp_both(e + 7, V_RUN);
      exp_both(e + 40, V_IDLE);
      exp_both(e + 49, V_RUN);
      key_run = 1'b0;
      repeat (40) @(negedge clk);
      clr = 1'b1;
      repeat (2) @(negedge clk);
      clr = 1'b0;
      repeat (58) @(negedge clk);
      key_run = 1'b1;
      idle(15);

      checks++;
      if (q_a.size() != 0) begin
         errors++;
         $display("FAIL dut_a pending: %0d expected changes never seen, expected 0", q_a.size());
      end
      checks++;
      if (q_b.size() != 0) begin
         errors++;
         $display("FAIL dut_b pending: %0d expected changes never seen, expected 0", q_b.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, SHALL set the stable-level time in clk cycles (20 ms at 50 MHz) before a key change is accepted.
REQ-002 Parameter STOP_AT_END, default 0, SHALL, when 1, make the block pause automatically on counter wrap.
REQ-003 clk  input  1  SHALL be the single 50 MHz system clock; all logic on its rising edge.
REQ-004 clr  input  1  SHALL be the synchronous, active-high reset.
REQ-005 key_run  input  1  SHALL be the raw push button, active-low and asynchronous: press toggles run/pause.
REQ-006 key_clr  input  1  SHALL be the raw push button, active-low and asynchronous: press clears the stopwatch.
REQ-007 ending  input  1  SHALL be the wrap indication from the downstream seconds counter.
REQ-008 start  output  1  SHALL be the downstream counter enable; 0 holds the counter at zero.
REQ-009 pause  output  1  SHALL be the downstream hold; 1 freezes the count.
REQ-010 cnt_clr  output  1  SHALL be a one-cycle clear pulse to the downstream counter.
REQ-011 state  output  2  SHALL be the FSM state: 00 IDLE, 01 RUN, 10 PAUSE; 11 is unused.

Function
REQ-012 Each key SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Debounce per key: the 20-bit counter SHALL increment each cycle the synchronized level differs from the debounced level, and SHALL reset to 0 on any cycle they match.
REQ-014 When a debounce counter reaches DEBOUNCE_CYCLES, the debounced level SHALL flip and that counter SHALL return to 0 on the same edge.
REQ-015 A press event SHALL be a registered one-cycle pulse on a debounced 1->0 transition; releases (0->1) SHALL generate no event.
REQ-016 Latency: from the first rising edge that samples a raw key low (held stable), the state change SHALL occur on exactly edge DEBOUNCE_CYCLES+4.
REQ-017 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL produce no event.
REQ-018 FSM transitions: IDLE+run_press->RUN; RUN+run_press->PAUSE; PAUSE+run_press->RUN.
REQ-019 Any state+clr_press SHALL go to IDLE and assert cnt_clr for exactly the one cycle in which state becomes IDLE.
REQ-020 If STOP_AT_END=1 and ending=1 in RUN, the FSM SHALL go to PAUSE; with STOP_AT_END=0, ending SHALL be ignored.
REQ-021 Priority for simultaneous events SHALL be clr_press > ending > run_press.
REQ-022 In RUN, ending and run_press arriving together SHALL yield PAUSE, with no double toggle.
REQ-023 Outputs SHALL be registered and decoded from state: IDLE start=0,pause=0; RUN start=1,pause=0; PAUSE start=1,pause=1.
REQ-024 A key held continuously SHALL produce exactly one event, and SHALL produce no further event until it is released and debounced high.
REQ-025 The two keys SHALL be debounced independently; activity on one SHALL NOT affect the other's counter.

Reset
REQ-026 clr=1 at a rising edge SHALL set state=IDLE, start=0, pause=0, cnt_clr=0, both synchronizers and debounced levels=1 (released), and both counters=0.
REQ-027 clr asserted mid-debounce or mid-RUN SHALL discard any pending event, with no pulse after reset release.
REQ-028 A key held low through reset release SHALL be treated as a new press after DEBOUNCE_CYCLES+4 cycles.
REQ-029 An unused state encoding of 11 SHALL recover to IDLE on the next edge.

Verification (DEBOUNCE_CYCLES=4)
REQ-030 After reset, hold key_run=0 for 20 cycles -> start rises exactly 8 edges after the first low sample, pause stays 0, state=01.
REQ-031 In RUN, a 3-cycle key_run low glitch -> no change; then a clean 10-cycle press -> state=10, start=1, pause=1.
REQ-032 In PAUSE, press key_clr -> state=00, start=0, pause=0, cnt_clr high for exactly 1 cycle.
REQ-033 Press key_run and key_clr with identical timing from RUN -> state=00 with one cnt_clr pulse, not PAUSE.
REQ-034 With STOP_AT_END=1 in RUN, pulse ending for 1 cycle -> state=10 next edge; repeat with STOP_AT_END=0 -> state stays 01.
REQ-035 Hold key_run low for 100 cycles from IDLE -> exactly one transition (to RUN); assert clr mid-hold -> IDLE, no spurious pulse.
